// File: rtl/smart_led_pkg.sv
// Shared types and timing defaults for the smart-LED node.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package smart_led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_ERROR = 2'd3
    } led_state_e;

    // Defaults for a 50 MHz core clock.
    localparam int DEF_T_THRESH = 30;
    localparam int DEF_T_RESET  = 2500;
    localparam int DEF_T_STUCK  = 250;

    function automatic int cnt_width(input int t_reset, input int t_stuck);
        int m;
        m = (t_reset > t_stuck) ? t_reset : t_stuck;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/smart_led_decoder_if.sv
// Serial line and LED drive signals of one smart-LED node.
// Latency: n/a (wiring only).
// Backpressure: none; the serial stream is free-running.
interface smart_led_if #(
    parameter int CHANNELS = 3
);
    logic                din;
    logic                dout;
    logic [CHANNELS-1:0] pwm_out;
    logic                frame_done;
    logic                busy;

    modport master (output din, input dout, pwm_out, frame_done, busy);
    modport slave  (input din, output dout, pwm_out, frame_done, busy);
endinterface

// File: rtl/smart_led_pwm.sv
// One PWM channel: holds the active duty value and compares it with the shared counter.
// Latency: 1 cycle from counter to pwm_out; a load takes effect on the following compare.
// Backpressure: none.
module smart_led_pwm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_vld,
    input  logic [WIDTH-1:0] load_dat,
    input  logic [WIDTH-1:0] pwm_cnt,
    output logic             pwm_out
);
    logic [WIDTH-1:0] active_q, active_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        active_d = load_vld ? load_dat : active_q;
        pwm_d    = (active_q > pwm_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;
endmodule

// File: rtl/smart_led_decoder.sv
// WS2812-style node: decodes pulse-width bits, keeps the first CHANNELS*WIDTH, forwards the rest.
// Latency: din->dout 3 cycles; frame_done T_RESET cycles after the last synchronised fall.
// Backpressure: none; the line cannot be stalled, faults are absorbed by the ERROR state.
module smart_led_decoder
    import smart_led_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int T_THRESH = DEF_T_THRESH,
    parameter int T_RESET  = DEF_T_RESET,
    parameter int T_STUCK  = DEF_T_STUCK
) (
    input  logic       clk,
    input  logic       rst_n,
    smart_led_if.slave bus
);
    localparam int NBITS = CHANNELS * WIDTH;
    localparam int CW    = cnt_width(T_RESET, T_STUCK);
    localparam int BW    = $clog2(NBITS + 1);

    localparam logic [CW-1:0] THRESH_CNT = CW'(T_THRESH);
    localparam logic [CW-1:0] RESET_CNT  = CW'(T_RESET);
    localparam logic [CW-1:0] STUCK_CNT  = CW'(T_STUCK);
    localparam logic [BW-1:0] NBITS_CNT  = BW'(NBITS);
    localparam logic [BW-1:0] LAST_CNT   = BW'(NBITS - 1);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_HIGH  = ST_HIGH;
    localparam logic [1:0] S_LOW   = ST_LOW;
    localparam logic [1:0] S_ERROR = ST_ERROR;

    logic             din_m_q, din_m_d;
    logic             din_s_q, din_s_d;
    logic             din_p_q, din_p_d;
    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             fwd_en_q, fwd_en_d;
    logic             dout_q, dout_d;
    logic             frame_done_q, frame_done_d;
    logic [WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;

    logic             rise, fall;
    logic [CW-1:0]    cnt_inc;
    logic             bit_vld, bit_val;
    logic             frame_end, latch;
    logic [CHANNELS-1:0] pwm_vec;

    always_comb begin
        din_m_d      = bus.din;
        din_s_d      = din_m_q;
        din_p_d      = din_s_q;
        rise         = din_s_q & ~din_p_q;
        fall         = ~din_s_q & din_p_q;
        cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        fwd_en_d     = fwd_en_q;
        bit_vld      = 1'b0;
        bit_val      = 1'b0;
        frame_end    = 1'b0;

        case (state_q)
            // Level test so a rise coinciding with a frame end is not lost.
            S_IDLE: begin
                if (din_s_q) begin
                    state_d = S_HIGH;
                    cnt_d   = CW'(1);
                end
            end
            S_HIGH: begin
                if (fall) begin
                    bit_vld = 1'b1;
                    bit_val = (cnt_q >= THRESH_CNT);
                    state_d = S_LOW;
                    cnt_d   = CW'(1);
                end else if (cnt_inc >= STUCK_CNT) begin
                    state_d   = S_ERROR;
                    cnt_d     = '0;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    fwd_en_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_LOW: begin
                if (cnt_inc >= RESET_CNT) begin
                    frame_end = 1'b1;
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    fwd_en_d  = 1'b0;
                end else if (rise) begin
                    state_d = S_HIGH;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_ERROR: begin
                if (din_s_q) begin
                    cnt_d = '0;
                end else if (cnt_inc >= RESET_CNT) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Own bits only; once saturated the node is a pure repeater.
        if (bit_vld && (bit_cnt_q < NBITS_CNT)) begin
            shift_d   = {shift_q[NBITS-2:0], bit_val};
            bit_cnt_d = bit_cnt_q + BW'(1);
            if (bit_cnt_q == LAST_CNT)
                fwd_en_d = 1'b1;
        end

        latch        = frame_end && (bit_cnt_q == NBITS_CNT);
        frame_done_d = latch;
        dout_d       = fwd_en_q & din_s_q;
        pwm_cnt_d    = pwm_cnt_q + WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_m_q      <= 1'b0;
            din_s_q      <= 1'b0;
            din_p_q      <= 1'b0;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            fwd_en_q     <= 1'b0;
            dout_q       <= 1'b0;
            frame_done_q <= 1'b0;
            pwm_cnt_q    <= '0;
        end else begin
            din_m_q      <= din_m_d;
            din_s_q      <= din_s_d;
            din_p_q      <= din_p_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            fwd_en_q     <= fwd_en_d;
            dout_q       <= dout_d;
            frame_done_q <= frame_done_d;
            pwm_cnt_q    <= pwm_cnt_d;
        end
    end

    // Channel 0 arrives first, so it sits in the top WIDTH bits.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        smart_led_pwm #(.WIDTH(WIDTH)) u_pwm (
            .clk      (clk),
            .rst_n    (rst_n),
            .load_vld (latch),
            .load_dat (shift_q[NBITS-1-i*WIDTH -: WIDTH]),
            .pwm_cnt  (pwm_cnt_q),
            .pwm_out  (pwm_vec[i])
        );
    end

    assign bus.dout       = dout_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.pwm_out    = pwm_vec;
endmodule

// File: doc/smart_led_decoder.md
# smart_led_decoder

Parametrised single-wire smart-LED node for the Tiny Tapeout smart-LED design. Decodes a WS2812-style pulse-width-coded serial stream, captures the first CHANNELS×WIDTH bits as its own colour data, forwards all later bits to the next node in the chain, and drives one PWM output per channel. On an idle-low reset gap it atomically latches the captured data into the PWM stage. It sits between the top-level input pin and the LED driver pins.

## Interface
- CHANNELS, 3: number of colour channels.
- WIDTH, 8: bits per channel; PWM resolution.
- T_THRESH, 30: high-pulse length in clk cycles at or above which a bit decodes as 1.
- T_RESET, 2500: low time in clk cycles that ends a frame (50 µs at 50 MHz).
- T_STUCK, 250: high time in clk cycles treated as a line fault.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  1  serial data in, asynchronous to clk.
- dout  out  1  serial data forwarded to the next node, registered.
- pwm_out  out  CHANNELS  PWM drive; bit i belongs to channel i.
- frame_done  out  1  single-cycle pulse when a complete frame is latched.
- busy  out  1  high while the FSM is not IDLE.

## Operation
- din passes through a 2-flop synchroniser (din_s); all logic uses din_s and its edges.
- FSM states:
  - IDLE → HIGH on a din_s rise; pulse counter cleared.
  - HIGH: counter runs.
    - din_s falls → decode bit: 1 if count ≥ T_THRESH, else 0. Go to LOW with the counter cleared.
    - count reaches T_STUCK → ERROR. Shift register and bit count are discarded.
  - LOW: counter runs.
    - din_s rises → HIGH.
    - count reaches T_RESET → frame end, then IDLE.
  - ERROR → IDLE once din_s has been continuously low for T_RESET cycles. No latch occurs.
- Capture: while bit_cnt < CHANNELS×WIDTH, each decoded bit shifts in MSB-first. Channel 0 is received first. bit_cnt increments per bit.
- Forwarding:
  - fwd_en is set when bit_cnt reaches CHANNELS×WIDTH.
  - While fwd_en is high, dout = registered din_s. Otherwise dout = 0.
  - Own bits are never forwarded.
  - Bits beyond the node's own bits are not counted; bit_cnt saturates.
- Frame end:
  - If bit_cnt == CHANNELS×WIDTH, the shift register is copied to the active registers and frame_done pulses.
  - A partial frame is discarded and the active values are unchanged.
  - bit_cnt, fwd_en and the counters are cleared in both cases.
- PWM:
  - A free-running WIDTH-bit counter, shared by all channels, wraps at 2^WIDTH−1 → 0.
  - pwm_out[i] = (active[i] > pwm_cnt), registered.
  - Value 0 → always low. Value 2^WIDTH−1 → high 2^WIDTH−1 of every 2^WIDTH cycles.
- Counter widths fit max(T_RESET, T_STUCK) and saturate; they never wrap.
- Reset mid-frame: all state is cleared immediately and the next frame is captured from its first bit.

## Timing
- Reset values: dout=0, pwm_out=0, frame_done=0, busy=0. Active registers, shift register, bit_cnt, pwm_cnt and FSM are all zero/IDLE.
- din → dout latency: 3 clk cycles (2 synchroniser flops + output register). Pulse widths are preserved exactly.
- fwd_en is set in the cycle the last own bit is decoded (the falling edge). The next bit's rising edge is therefore forwarded whole.
- frame_done is asserted in the cycle the LOW counter reaches T_RESET. The active registers update on that same edge.
- pwm_out reflects new values from the next PWM counter tick; the PWM period is not restarted.
- Simultaneous din_s rise and LOW count reaching T_RESET: the frame end wins, and the rise is handled from IDLE in the next cycle.

## Structure
- Package smart_led_pkg:
  - FSM state enum (IDLE, HIGH, LOW, ERROR).
  - Default timing constants for a 50 MHz clock.
  - Function computing counter width from T_RESET/T_STUCK.
- Sub-module smart_led_pwm: one active register compare plus output flop, instantiated CHANNELS times. It is fed by the shared counter.

## Test plan
All scenarios use defaults: 20-cycle high = 0, 40-cycle high = 1, 60-cycle bit period.
- Reset with din=0 → all outputs 0, busy=0; after reset, pwm_out stays 0 for 512 cycles.
- Frame 0xFF,0x80,0x00 then 2600 low cycles → frame_done pulses once 2500 cycles after the last fall.
  - pwm_out[0] high 255 of 256 cycles.
  - pwm_out[1] high 128 of 256 cycles.
  - pwm_out[2] always low.
- 48-bit frame → first 24 bits captured and dout stays 0 during them. Bits 25–48 appear on dout delayed by 3 cycles with identical pulse widths.
- 12-bit partial frame then reset gap → no frame_done; prior PWM duty is unchanged.
- din held high for 300 cycles mid-frame → ERROR. After 2500 low cycles → IDLE with no latch; a following full frame latches correctly.
- rst_n asserted for 1 cycle at bit 10 of a frame → outputs 0 immediately; a subsequent full frame latches correctly.
